// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcode constants, bus widths and the
// load-unit state encoding.
package tomasulo_pkg;

   localparam int LABEL_W = 5;
   localparam int DATA_W  = 32;
   localparam int OP_W    = 5;

   localparam logic [OP_W-1:0] OP_LW = 5'h03;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_WB   = 2'd2
   } lu_state_e;

endpackage

// File: rtl/load_unit_if.sv
// Load-unit bus bundle: issue port from the reservation station, data-memory
// read handshake, common-data-bus arbitration and the broadcast outputs.
// The slave modport is the load unit itself.
interface load_unit_if;
   import tomasulo_pkg::*;

   logic                 issue_valid;
   logic [OP_W-1:0]      issue_op;
   logic [DATA_W-1:0]    issue_base;
   logic [DATA_W-1:0]    issue_imm;
   logic [LABEL_W-1:0]   issue_label;
   logic                 ready;

   logic                 mem_req;
   logic [DATA_W-1:0]    mem_addr;
   logic                 mem_ack;
   logic [DATA_W-1:0]    mem_rdata;

   logic                 cdb_req;
   logic                 cdb_gnt;

   logic                 BCEN;
   logic [LABEL_W-1:0]   BClabel;
   logic [DATA_W-1:0]    BCdata;
   logic                 ld_err;

   modport slave (
      input  issue_valid, issue_op, issue_base, issue_imm, issue_label,
      output ready,
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      output cdb_req,
      input  cdb_gnt,
      output BCEN, BClabel, BCdata, ld_err
   );

   modport master (
      output issue_valid, issue_op, issue_base, issue_imm, issue_label,
      input  ready,
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      input  cdb_req,
      output cdb_gnt,
      input  BCEN, BClabel, BCdata, ld_err
   );

endinterface

// File: rtl/load_unit.sv
// Tomasulo load unit: accepts one load from the reservation station, reads
// data memory with a bounded wait, then broadcasts the result on the CDB.
// Optional feature: define LOAD_UNIT_ALIGN_CHK_EN to fault misaligned LW
// addresses instead of silently word-aligning them on mem_addr.
module load_unit
   import tomasulo_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 15
)(
   input  logic        clk,
   input  logic        rst,
   load_unit_if.slave  lu
);

   // Last wait-counter value before the memory read is abandoned.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

`ifdef LOAD_UNIT_ALIGN_CHK_EN
   localparam logic [DATA_W-1:0] ADDR_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [DATA_W-1:0] ADDR_MASK = 32'hFFFF_FFFC;
`endif

   lu_state_e            state_r;
   logic [LABEL_W-1:0]   label_r;
   logic [OP_W-1:0]      op_r;
   logic [DATA_W-1:0]    addr_r;
   logic [DATA_W-1:0]    data_r;
   logic                 err_r;
   logic [7:0]           wait_cnt_r;

   logic                 accept_s;
   logic [DATA_W-1:0]    eff_addr_s;
   logic                 misalign_s;
   logic                 is_lw_s;

   // Decode the issue port: acceptance, effective address and alignment fault.
   always_comb begin
      accept_s   = lu.issue_valid && (state_r == ST_IDLE) &&
                   (lu.issue_label != {LABEL_W{1'b0}});
      eff_addr_s = lu.issue_base + lu.issue_imm;
      is_lw_s    = (lu.issue_op == OP_LW);
`ifdef LOAD_UNIT_ALIGN_CHK_EN
      misalign_s = is_lw_s && (eff_addr_s[1:0] != 2'b00);
`else
      misalign_s = 1'b0;
`endif
   end

   // Single FSM: accept entry, wait for memory with timeout, broadcast on CDB.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         label_r    <= {LABEL_W{1'b0}};
         op_r       <= {OP_W{1'b0}};
         addr_r     <= {DATA_W{1'b0}};
         data_r     <= {DATA_W{1'b0}};
         err_r      <= 1'b0;
         wait_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  label_r    <= lu.issue_label;
                  op_r       <= lu.issue_op;
                  addr_r     <= eff_addr_s;
                  data_r     <= {DATA_W{1'b0}};
                  wait_cnt_r <= 8'd0;
                  err_r      <= misalign_s;
                  state_r    <= (is_lw_s && !misalign_s) ? ST_MEM : ST_WB;
               end
            end
            ST_MEM: begin
               if (lu.mem_ack) begin
                  data_r  <= lu.mem_rdata;
                  state_r <= ST_WB;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  data_r  <= {DATA_W{1'b0}};
                  err_r   <= 1'b1;
                  state_r <= ST_WB;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            ST_WB: begin
               if (lu.cdb_gnt) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from registered state; the broadcast is qualified
   // by the grant so it can never appear on the bus without one.
   always_comb begin
      lu.ready    = (state_r == ST_IDLE);
      lu.mem_req  = (state_r == ST_MEM) && (op_r == OP_LW);
      lu.mem_addr = lu.mem_req ? (addr_r & ADDR_MASK) : {DATA_W{1'b0}};
      lu.cdb_req  = (state_r == ST_WB);
      lu.BCEN     = lu.cdb_req && lu.cdb_gnt;
      lu.BClabel  = lu.BCEN ? label_r : {LABEL_W{1'b0}};
      lu.BCdata   = lu.BCEN ? data_r  : {DATA_W{1'b0}};
      lu.ld_err   = lu.BCEN && err_r;
   end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed corner cases followed by
// randomized loads compared against a transaction-level reference model.
module tb_load_unit;
   import tomasulo_pkg::*;

   localparam int TIMEOUT = 15;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   load_unit_if lu();

   load_unit #(.TIMEOUT_CYC(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .lu  (lu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete load transaction. The expected behaviour is derived from
   // the transaction parameters: where the address goes, how many memory
   // cycles mem_req stays up, and what the broadcast must carry.
   task automatic run_load(input logic [31:0] base, input logic [31:0] imm,
                           input logic [4:0] label, input logic [4:0] op,
                           input int ack_delay, input logic [31:0] rdata,
                           input int gnt_delay);
      logic        is_lw, misalign, goes_mem, timed_out, exp_err;
      logic [31:0] exp_addr, exp_data, sum;
      int          mem_cycles;
      sum       = base + imm;
      is_lw     = (op == OP_LW);
`ifdef LOAD_UNIT_ALIGN_CHK_EN
      misalign  = is_lw && (sum % 4 != 0);
      exp_addr  = sum;
`else
      misalign  = 1'b0;
      exp_addr  = sum - (sum % 4);
`endif
      goes_mem  = is_lw && !misalign;
      timed_out = goes_mem && (ack_delay >= TIMEOUT);
      exp_data  = (goes_mem && !timed_out) ? rdata : 32'd0;
      exp_err   = misalign || timed_out;
      mem_cycles = goes_mem ? (timed_out ? TIMEOUT : ack_delay + 1) : 0;

      @(negedge clk);
      lu.issue_valid = 1'b1;
      lu.issue_op    = op;
      lu.issue_base  = base;
      lu.issue_imm   = imm;
      lu.issue_label = label;
      #1;
      check("ready_before_issue", 32'(lu.ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      lu.issue_valid = 1'b0;
      lu.issue_op    = 5'($urandom());
      lu.issue_base  = $urandom();
      lu.issue_imm   = $urandom();
      lu.issue_label = 5'($urandom());

      for (int i = 0; i < mem_cycles; i++) begin
         lu.mem_ack   = (i == ack_delay);
         lu.mem_rdata = (i == ack_delay) ? rdata : $urandom();
         #1;
         check("mem_req_in_mem", 32'(lu.mem_req), 32'd1);
         check("mem_addr", lu.mem_addr, exp_addr);
         check("ready_in_mem", 32'(lu.ready), 32'd0);
         check("bcen_in_mem", 32'(lu.BCEN), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      lu.mem_ack = 1'b0;

      for (int j = 0; j <= gnt_delay; j++) begin
         lu.cdb_gnt = (j == gnt_delay);
         lu.mem_ack = 1'($urandom_range(0, 1));
         #1;
         check("cdb_req_in_wb", 32'(lu.cdb_req), 32'd1);
         check("mem_req_in_wb", 32'(lu.mem_req), 32'd0);
         check("ready_in_wb", 32'(lu.ready), 32'd0);
         check("bcen", 32'(lu.BCEN), (j == gnt_delay) ? 32'd1 : 32'd0);
         check("bclabel", 32'(lu.BClabel), (j == gnt_delay) ? 32'(label) : 32'd0);
         check("bcdata", lu.BCdata, (j == gnt_delay) ? exp_data : 32'd0);
         check("ld_err", 32'(lu.ld_err), (j == gnt_delay) ? 32'(exp_err) : 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      lu.cdb_gnt = 1'b0;
      lu.mem_ack = 1'b0;
      #1;
      check("ready_after_bc", 32'(lu.ready), 32'd1);
      check("bcen_after_bc", 32'(lu.BCEN), 32'd0);
   endtask

   initial begin
      logic [4:0] rop;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      lu.issue_valid = 1'b0;
      lu.issue_op    = 5'd0;
      lu.issue_base  = 32'd0;
      lu.issue_imm   = 32'd0;
      lu.issue_label = 5'd0;
      lu.mem_ack     = 1'b0;
      lu.mem_rdata   = 32'd0;
      lu.cdb_gnt     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_ready", 32'(lu.ready), 32'd1);
      check("rst_mem_req", 32'(lu.mem_req), 32'd0);
      check("rst_mem_addr", lu.mem_addr, 32'd0);
      check("rst_cdb_req", 32'(lu.cdb_req), 32'd0);
      check("rst_bcen", 32'(lu.BCEN), 32'd0);
      check("rst_bclabel", 32'(lu.BClabel), 32'd0);
      check("rst_bcdata", lu.BCdata, 32'd0);
      check("rst_ld_err", 32'(lu.ld_err), 32'd0);
      rst = 1'b0;

      // Basic load, ack after 2 wait cycles
      run_load(32'h100, 32'h8, 5'd3, OP_LW, 2, 32'hCAFEF00D, 0);
      // Address wrap
      run_load(32'hFFFF_FFFC, 32'h8, 5'd7, OP_LW, 0, 32'h1234_5678, 0);
      // Minimum latency path
      run_load(32'h2000, 32'h4, 5'd31, OP_LW, 0, 32'hA5A5_5A5A, 0);
      // Memory timeout
      run_load(32'h300, 32'h0, 5'd9, OP_LW, 40, 32'hDEAD_BEEF, 0);
      // Ack on the very last allowed wait cycle still succeeds
      run_load(32'h400, 32'h0, 5'd10, OP_LW, TIMEOUT - 1, 32'h0BAD_F00D, 1);
      // Grant withheld for 10 cycles
      run_load(32'h500, 32'h10, 5'd12, OP_LW, 1, 32'h5555_AAAA, 10);
      // Non-load opcode bypasses memory
      run_load(32'h600, 32'h4, 5'd5, 5'h01, 0, 32'hFFFF_FFFF, 2);
      // Misaligned address
      run_load(32'h100, 32'h2, 5'd4, OP_LW, 0, 32'h7777_7777, 0);

      // Label 0 is never accepted
      @(negedge clk);
      lu.issue_valid = 1'b1;
      lu.issue_op    = OP_LW;
      lu.issue_base  = 32'h800;
      lu.issue_imm   = 32'h0;
      lu.issue_label = 5'd0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         check("lbl0_ready", 32'(lu.ready), 32'd1);
         check("lbl0_mem_req", 32'(lu.mem_req), 32'd0);
         check("lbl0_cdb_req", 32'(lu.cdb_req), 32'd0);
      end
      lu.issue_valid = 1'b0;

      // Reset during MEM, followed by a late ack
      @(negedge clk);
      lu.issue_valid = 1'b1;
      lu.issue_label = 5'd6;
      @(posedge clk);
      @(negedge clk);
      lu.issue_valid = 1'b0;
      #1;
      check("pre_rst_mem_req", 32'(lu.mem_req), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      lu.mem_ack   = 1'b1;
      lu.mem_rdata = 32'h1111_2222;
      lu.cdb_gnt   = 1'b1;
      #1;
      check("rstmem_ready", 32'(lu.ready), 32'd1);
      check("rstmem_mem_req", 32'(lu.mem_req), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         check("rstmem_bcen", 32'(lu.BCEN), 32'd0);
         check("rstmem_cdb_req", 32'(lu.cdb_req), 32'd0);
      end
      lu.mem_ack = 1'b0;
      lu.cdb_gnt = 1'b0;

      // Reset during WB
      @(negedge clk);
      lu.issue_valid = 1'b1;
      lu.issue_op    = 5'h02;
      lu.issue_label = 5'd8;
      @(posedge clk);
      @(negedge clk);
      lu.issue_valid = 1'b0;
      #1;
      check("pre_rst_cdb_req", 32'(lu.cdb_req), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      lu.cdb_gnt = 1'b1;
      #1;
      check("rstwb_bcen", 32'(lu.BCEN), 32'd0);
      check("rstwb_ready", 32'(lu.ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      lu.cdb_gnt = 1'b0;

      // Randomized loads
      for (int t = 0; t < 25; t++) begin
         rop = 5'($urandom_range(0, 31));
         if (rop == OP_LW) rop = rop ^ 5'd1;
         run_load($urandom(), $urandom(), 5'($urandom_range(1, 31)),
                  ($urandom_range(0, 3) == 0) ? rop : OP_LW,
                  int'($urandom_range(0, 17)), $urandom(),
                  int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
